// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: STAGES-deep synchronizer, per-channel
// stability filter, and registered one-cycle rise/fall strobes.
module sync_debounce #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               DB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             db_bypass,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] rise_next_vec;
  logic [WIDTH-1:0] fall_next_vec;
  logic             changed_reg;
  logic             changed_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [STAGES-1:0] chain_reg;
      logic [CW-1:0]     cnt_reg;
      logic [CW-1:0]     cnt_next;
      logic              sync_s;
      logic              dout_reg;
      logic              dout_next;
      logic              rise_reg;
      logic              rise_next;
      logic              fall_reg;
      logic              fall_next;

      // Plain shift chain; nothing may sit between the stages.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain_reg <= {STAGES{RESET_VAL[gi]}};
        end else begin
          chain_reg <= {chain_reg[STAGES-2:0], din[gi]};
        end
      end

      assign sync_s = chain_reg[STAGES-1];

      // Any cycle where the synchronized level matches dout (or bypass is on)
      // leaves the counter at zero, so partial progress never survives.
      always_comb begin
        cnt_next  = '0;
        dout_next = dout_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (sync_s != dout_reg) begin
          if (db_bypass || (cnt_reg == CNT_MAX)) begin
            dout_next = sync_s;
            rise_next = sync_s;
            fall_next = ~sync_s;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg  <= '0;
          dout_reg <= RESET_VAL[gi];
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          dout_reg <= dout_next;
          rise_reg <= rise_next;
          fall_reg <= fall_next;
        end
      end

      assign dout[gi]          = dout_reg;
      assign rise[gi]          = rise_reg;
      assign fall[gi]          = fall_reg;
      assign rise_next_vec[gi] = rise_next;
      assign fall_next_vec[gi] = fall_next;
    end
  endgenerate

  // Built from the next-state strobes so it lines up with rise/fall.
  assign changed_next = |(rise_next_vec | fall_next_vec);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= changed_next;
    end
  end

  assign changed = changed_reg;

endmodule

// File: tb/tb_sync_debounce.sv
// Randomized and directed bench for sync_debounce against a window-based
// reference model of the synchronizer delay and stability filter.
module tb_sync_debounce;

  localparam int W    = 4;
  localparam int ST   = 2;
  localparam int DB   = 4;
  localparam logic [W-1:0] RV = '0;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         db_bypass = 1'b0;
  logic [W-1:0] dout, rise, fall;
  logic         changed;

  int ncomp = 0;
  int nfail = 0;

  // Reference model state: histories indexed by edge number since reset release.
  logic [W-1:0] din_hist [MAXE];
  logic [W-1:0] sb_hist  [MAXE];
  logic         byp_hist [MAXE];
  int           n;
  logic [W-1:0] m_dout, m_rise, m_fall;
  logic         m_changed;

  sync_debounce #(.WIDTH(W), .STAGES(ST), .DB_CYCLES(DB), .RESET_VAL(RV)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .db_bypass(db_bypass),
    .dout(dout), .rise(rise), .fall(fall), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_dout = RV;
    m_rise = '0;
    m_fall = '0;
    m_changed = 1'b0;
  endtask

  // s seen at edge n is din sampled STAGES edges earlier; the filter fires when
  // the last DB samples all differ from dout with bypass off for all of them.
  task automatic model_edge();
    logic [W-1:0] sb, nd;
    bit ok;
    if (n >= MAXE) begin
      $display("FAIL model_overflow: observed edge %0d required below %0d", n, MAXE);
      $fatal(1);
    end
    sb = (n >= ST) ? din_hist[n-ST] : RV;
    din_hist[n] = din;
    sb_hist[n]  = sb;
    byp_hist[n] = db_bypass;
    nd = m_dout;
    for (int i = 0; i < W; i++) begin
      if (db_bypass) begin
        nd[i] = sb[i];
      end else if (n >= DB - 1) begin
        ok = 1'b1;
        for (int k = n - DB + 1; k <= n; k++)
          if (byp_hist[k] || (sb_hist[k][i] == m_dout[i])) ok = 1'b0;
        if (ok) nd[i] = sb[i];
      end
    end
    m_rise    = nd & ~m_dout;
    m_fall    = ~nd & m_dout;
    m_changed = |(m_rise | m_fall);
    m_dout    = nd;
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("dout", dout, m_dout);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("changed", {3'b000, changed}, {3'b000, m_changed});
  endtask

  // Asynchronous assertion a little after a posedge, checked before the next edge.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_dout", dout, RV);
    check("rst_rise", rise, '0);
    check("rst_fall", fall, '0);
    check("rst_changed", {3'b000, changed}, 4'b0000);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  int hold_cnt [W];

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("por_dout", dout, RV);
    check("por_rise", rise, '0);
    reset_n = 1'b1;
    model_reset();

    // Idle after reset: no spurious pulses.
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_dout", dout, 4'b0000);
      check("idle_changed", {3'b000, changed}, 4'b0000);
    end
    $display("phase idle: 20 cycles, din=0000");

    // Channel 0 rises then falls, both after STAGES+DB_CYCLES-1 edges.
    din = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("ch0_rise_time", rise, (k == 5) ? 4'b0001 : 4'b0000);
    end
    din = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("ch0_fall_time", fall, (k == 5) ? 4'b0001 : 4'b0000);
    end
    $display("phase ch0: rise and fall after 5 edges");

    // Short glitch on channel 1 is rejected; a DB-long pulse passes.
    din = 4'b0010;
    repeat (3) tick();
    din = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_dout1", {3'b000, dout[1]}, 4'b0000);
    end
    din = 4'b0010;
    repeat (4) tick();
    din = 4'b0000;
    repeat (12) tick();
    $display("phase glitch: 3-cycle rejected, 4-cycle passed");

    // Bypass: channel 2 toggles every 2 cycles and dout follows at STAGES.
    db_bypass = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din[2] = (k / 2) % 2 == 1;
      tick();
    end
    din = 4'b0000;
    repeat (4) tick();
    db_bypass = 1'b0;
    repeat (6) tick();
    $display("phase bypass: channel 2 toggling");

    // All channels rise together.
    din = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("all_rise", rise, (k == 5) ? 4'b1111 : 4'b0000);
    end
    din = 4'b0000;
    repeat (12) tick();
    $display("phase all: simultaneous rise and fall");

    // Reset in the middle of a channel 3 transition while others are high.
    din = 4'b0111;
    repeat (10) tick();
    din = 4'b1111;
    repeat (3) tick();
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_rst_rise", rise, (k == ST + DB - 1) ? 4'b1111 : 4'b0000);
    end
    din = 4'b0000;
    repeat (10) tick();
    $display("phase reset: mid-count reset, rise %0d edges after release", ST + DB - 1);

    // Random levels with random hold times and occasional bypass toggles.
    for (int i = 0; i < W; i++) hold_cnt[i] = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < W; i++) begin
        if (hold_cnt[i] == 0) begin
          din[i] = ~din[i];
          hold_cnt[i] = $urandom_range(1, 8);
        end else begin
          hold_cnt[i]--;
        end
      end
      if ($urandom_range(0, 39) == 0) db_bypass = ~db_bypass;
      if (t == 200) do_reset(1);
      tick();
    end
    db_bypass = 1'b0;
    $display("phase random: 400 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
